// File: rtl/led_activity_pkg.sv
// Shared types and helpers for the LED activity stretcher.
package led_activity_pkg;

  typedef enum logic [1:0] {
    LedIdle = 2'd0,
    LedOn   = 2'd1,
    LedGap  = 2'd2
  } led_state_e;

  // Counter width able to hold the longer of the two phase lengths.
  function automatic int unsigned cnt_width(int unsigned on, int unsigned off);
    int unsigned longest;
    longest = (on > off) ? on : off;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/led_activity_chan.sv
// One LED channel: stretches activity strobes into an on-phase followed by an off-gap.
module led_activity_chan
  import led_activity_pkg::*;
#(
  parameter int unsigned OnCount  = 500,
  parameter int unsigned OffCount = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic event_i,
  output logic led_on_o,
  output logic busy_o
);

  localparam int unsigned CntW = cnt_width(OnCount, OffCount);

  if (OnCount < 1 || OffCount < 1) begin : gen_param_check
    $error("led_activity_chan: OnCount and OffCount must be >= 1");
  end

  localparam logic [CntW-1:0] OnLast  = CntW'(OnCount - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(OffCount - 1);

  led_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;

  // State, counter, pending flag and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= LedIdle;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      led_on_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      led_on_o <= (state_d == LedOn);
      busy_o   <= (state_d != LedIdle);
    end
  end

  // Next-state logic; a phase always runs its full length, extra events only set pending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;

    if (!enable_i) begin
      state_d = LedIdle;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        LedIdle: begin
          if (event_i) begin
            state_d = LedOn;
            cnt_d   = '0;
          end
        end
        LedOn: begin
          pend_d = pend_q | event_i;
          if (cnt_q == OnLast) begin
            state_d = LedGap;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        LedGap: begin
          if (cnt_q == OffLast) begin
            state_d = (pend_q || event_i) ? LedOn : LedIdle;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + CntW'(1);
            pend_d = pend_q | event_i;
          end
        end
        default: begin
          state_d = LedIdle;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_activity.sv
// Multi-channel LED activity indicator: independent per-channel stretchers plus output polarity.
module led_activity
  import led_activity_pkg::*;
#(
  parameter int unsigned NumLeds   = 4,
  parameter int unsigned OnCount   = 500,
  parameter int unsigned OffCount  = 500,
  parameter bit          ActiveLow = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [NumLeds-1:0] event_i,
  output logic [NumLeds-1:0] led_o,
  output logic [NumLeds-1:0] busy_o
);

  if (NumLeds < 1 || OnCount < 1 || OffCount < 1) begin : gen_param_check
    $error("led_activity: NumLeds, OnCount and OffCount must all be >= 1");
  end

  logic [NumLeds-1:0] led_on;

  for (genvar i = 0; i < NumLeds; i++) begin : gen_chan
    led_activity_chan #(
      .OnCount (OnCount),
      .OffCount(OffCount)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable_i(enable_i),
      .event_i (event_i[i]),
      .led_on_o(led_on[i]),
      .busy_o  (busy_o[i])
    );
  end

  // Polarity applied once, directly on the registered lit flags.
  assign led_o = led_on ^ {NumLeds{ActiveLow}};

endmodule

// File: tb/tb_led_activity.sv
// Scoreboard bench for led_activity (OnCount=4, OffCount=3, two channels, both polarities).
module tb_led_activity;

  localparam int unsigned NumLeds  = 2;
  localparam int unsigned OnCount  = 4;
  localparam int unsigned OffCount = 3;

  typedef struct {
    logic [1:0] led;
    logic [1:0] busy;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [1:0] event_i;
  logic [1:0] led_o, busy_o;
  logic [1:0] led_al, busy_al;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  led_activity #(
    .NumLeds(NumLeds), .OnCount(OnCount), .OffCount(OffCount), .ActiveLow(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .event_i(event_i), .led_o(led_o), .busy_o(busy_o)
  );

  led_activity #(
    .NumLeds(NumLeds), .OnCount(OnCount), .OffCount(OffCount), .ActiveLow(1'b1)
  ) dut_al (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .event_i(event_i), .led_o(led_al), .busy_o(busy_al)
  );

  function automatic logic in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic do_reset();
    rst_i    = 1'b1;
    enable_i = 1'b1;
    event_i  = 2'b00;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Reset dominates active events; both polarities show an unlit LED.
  task automatic test_reset();
    exp_t e;
    rst_i    = 1'b1;
    enable_i = 1'b1;
    event_i  = 2'b11;
    for (int c = 0; c < 3; c++) begin
      e.led  = 2'b00;
      e.busy = 2'b00;
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      if (led_o !== e.led) begin n_fail++; $display("FAIL reset c%0d led_o got %b want %b", c + 1, led_o, e.led); end
      if (busy_o !== e.busy) begin n_fail++; $display("FAIL reset c%0d busy_o got %b want %b", c + 1, busy_o, e.busy); end
      if (led_al !== 2'b11) begin n_fail++; $display("FAIL reset c%0d led_al got %b want 11", c + 1, led_al); end
      if (busy_al !== e.busy) begin n_fail++; $display("FAIL reset c%0d busy_al got %b want %b", c + 1, busy_al, e.busy); end
      n_cmp += 4;
    end
    rst_i   = 1'b0;
    event_i = 2'b00;
  endtask

  // One strobe: lit cycles 1-4, busy 1-7; other channel untouched.
  task automatic test_single();
    exp_t e;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      event_i = (c == 0) ? 2'b01 : 2'b00;
      e.led  = {1'b0, in_rng(c + 1, 1, 4)};
      e.busy = {1'b0, in_rng(c + 1, 1, 7)};
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      if (led_o !== e.led) begin n_fail++; $display("FAIL single c%0d led_o got %b want %b", c + 1, led_o, e.led); end
      if (busy_o !== e.busy) begin n_fail++; $display("FAIL single c%0d busy_o got %b want %b", c + 1, busy_o, e.busy); end
      if (led_al !== ~e.led) begin n_fail++; $display("FAIL single c%0d led_al got %b want %b", c + 1, led_al, ~e.led); end
      n_cmp += 3;
    end
  endtask

  // Held event: regular 4-on / 3-off blink from cycle 1.
  task automatic test_held();
    exp_t e;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      event_i = 2'b01;
      e.led  = {1'b0, ((c % 7) < 4)};
      e.busy = 2'b01;
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      if (led_o !== e.led) begin n_fail++; $display("FAIL held c%0d led_o got %b want %b", c + 1, led_o, e.led); end
      if (busy_o !== e.busy) begin n_fail++; $display("FAIL held c%0d busy_o got %b want %b", c + 1, busy_o, e.busy); end
      n_cmp += 2;
    end
    event_i = 2'b00;
  endtask

  // Many events in one ON+GAP window give exactly one extra ON phase.
  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      event_i = (c == 0 || c == 2 || c == 3 || c == 5 || c == 7) ? 2'b01 : 2'b00;
      e.led  = {1'b0, in_rng(c + 1, 1, 4) || in_rng(c + 1, 8, 11)};
      e.busy = {1'b0, in_rng(c + 1, 1, 14)};
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      if (led_o !== e.led) begin n_fail++; $display("FAIL b2b c%0d led_o got %b want %b", c + 1, led_o, e.led); end
      if (busy_o !== e.busy) begin n_fail++; $display("FAIL b2b c%0d busy_o got %b want %b", c + 1, busy_o, e.busy); end
      n_cmp += 2;
    end
  endtask

  // Event in the last GAP cycle re-triggers; ch1 runs independently meanwhile.
  task automatic test_gap_edge();
    exp_t e;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      event_i = {(c == 0), (c == 0 || c == 7)};
      e.led  = {in_rng(c + 1, 1, 4), in_rng(c + 1, 1, 4) || in_rng(c + 1, 8, 11)};
      e.busy = {in_rng(c + 1, 1, 7), in_rng(c + 1, 1, 14)};
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      if (led_o !== e.led) begin n_fail++; $display("FAIL gap_edge c%0d led_o got %b want %b", c + 1, led_o, e.led); end
      if (busy_o !== e.busy) begin n_fail++; $display("FAIL gap_edge c%0d busy_o got %b want %b", c + 1, busy_o, e.busy); end
      n_cmp += 2;
    end
    // Fresh event after idling: 1-cycle latency from an arbitrary start.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      event_i = (c == 8) ? 2'b01 : 2'b00;
      e.led  = {1'b0, in_rng(c + 1, 9, 12)};
      e.busy = {1'b0, in_rng(c + 1, 9, 15)};
      sb.push_back(e);
      @(posedge clk_i); #1;
      e = sb.pop_front();
      if (led_o !== e.led) begin n_fail++; $display("FAIL late_evt c%0d led_o got %b want %b", c + 1, led_o, e.led); end
      if (busy_o !== e.busy) begin n_fail++; $display("FAIL late_evt c%0d busy_o got %b want %b", c + 1, busy_o, e.busy); end
      n_cmp += 2;
    end
  endtask

  // Mid-ON reset, then mid-ON enable drop (with events ignored while disabled).
  task automatic test_abort();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int c = 0; c < 14; c++) begin
        if (pass == 0) begin
          rst_i    = (c == 2);
          enable_i = 1'b1;
          event_i  = (c == 0 || c == 5) ? 2'b01 : 2'b00;
        end else begin
          rst_i    = 1'b0;
          enable_i = !in_rng(c, 2, 4);
          event_i  = (c == 0 || c == 5) ? 2'b01 : (c == 3) ? 2'b11 : 2'b00;
        end
        e.led  = {1'b0, in_rng(c + 1, 1, 2) || in_rng(c + 1, 6, 9)};
        e.busy = {1'b0, in_rng(c + 1, 1, 2) || in_rng(c + 1, 6, 12)};
        sb.push_back(e);
        @(posedge clk_i); #1;
        e = sb.pop_front();
        if (led_o !== e.led) begin n_fail++; $display("FAIL abort%0d c%0d led_o got %b want %b", pass, c + 1, led_o, e.led); end
        if (busy_o !== e.busy) begin n_fail++; $display("FAIL abort%0d c%0d busy_o got %b want %b", pass, c + 1, busy_o, e.busy); end
        if (led_al !== ~e.led) begin n_fail++; $display("FAIL abort%0d c%0d led_al got %b want %b", pass, c + 1, led_al, ~e.led); end
        n_cmp += 3;
      end
    end
    rst_i    = 1'b0;
    enable_i = 1'b1;
    event_i  = 2'b00;
  endtask

  initial begin
    rst_i    = 1'b1;
    enable_i = 1'b1;
    event_i  = 2'b00;
    #1;
    test_reset();
    test_single();
    test_held();
    test_back_to_back();
    test_gap_edge();
    test_abort();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftover got %0d entries want 0", sb.size());
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
